// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan
//
// Purpose:
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display
//   fed by the reaction-timer counter. Digits 0..2 show the ones, tens and
//   hundreds BCD digits. Digit 3 shows the rank of the one-hot overflow ladder.
//   The counter outputs are captured into a snapshot on a load strobe so the
//   display never shows a half-updated count.
//
// Optional feature:
//   Define BCD_DISPLAY_BLANK_EN to enable leading-zero blanking. A blanked
//   digit keeps its anode in the scan but drives all segments off. Without the
//   macro every digit is always shown.
//
// Parameters:
//   SCAN_DIV  - clock cycles each digit stays lit (2 .. 2^20)
//   PRESC_W   - prescaler width, 2^PRESC_W >= SCAN_DIV
//
// Ports:
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   load       in   1   snapshot strobe for one/ten/hun/overflow
//   one        in   4   BCD ones digit
//   ten        in   4   BCD tens digit
//   hun        in   4   BCD hundreds digit
//   overflow   in  10   one-hot overflow ladder, 0 = no overflow
//   an         out  4   digit anodes, active-low, an[0] = ones
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//   busy_digit out  2   index of the digit currently lit
// ---------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int PRESC_W  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [3:0]  one,
    input  logic [3:0]  ten,
    input  logic [3:0]  hun,
    input  logic [9:0]  overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  busy_digit
);

    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [3:0] CODE_BAD = 4'hF;

    // Active-low segment pattern for a BCD code; non-decimal codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    // Rank of the overflow ladder as a display code. No bit set gives 0, a
    // single bit k gives k+1 with rank 10 wrapping to 0, and an illegal
    // multi-bit ladder gives a non-decimal code so it renders as a dash.
    function automatic logic [3:0] ovf_rank(input logic [9:0] v);
        logic [3:0] cnt;
        logic [3:0] pos;
        logic [3:0] rank;
        cnt = 4'd0;
        pos = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                cnt = cnt + 4'd1;
                pos = 4'(i);
            end else begin
                cnt = cnt;
            end
        end
        if (cnt == 4'd0) begin
            rank = 4'd0;
        end else if (cnt != 4'd1) begin
            rank = CODE_BAD;
        end else if (pos == 4'd9) begin
            rank = 4'd0;
        end else begin
            rank = pos + 4'd1;
        end
        return rank;
    endfunction

    logic [PRESC_W-1:0] presc_r;
    logic [1:0]         idx_r;
    logic [3:0]         one_r;
    logic [3:0]         ten_r;
    logic [3:0]         hun_r;
    logic [9:0]         ovf_r;

    logic [3:0]         rank_s;
    logic [3:0]         code_s;
    logic               blank_s;
    logic [3:0]         an_next_s;
    logic [6:0]         seg_next_s;

    // Prescaler and digit index: the index steps each time the prescaler wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r <= PRESC_ZERO;
            idx_r   <= 2'd0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= PRESC_ZERO;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            idx_r   <= idx_r;
        end
    end

    // Snapshot of the counter outputs, captured together on load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            one_r <= 4'd0;
            ten_r <= 4'd0;
            hun_r <= 4'd0;
            ovf_r <= 10'd0;
        end else if (load) begin
            one_r <= one;
            ten_r <= ten;
            hun_r <= hun;
            ovf_r <= overflow;
        end else begin
            one_r <= one_r;
            ten_r <= ten_r;
            hun_r <= hun_r;
            ovf_r <= ovf_r;
        end
    end

    // Select the code, anode and blanking state for the digit being scanned.
    always_comb begin
        rank_s    = ovf_rank(ovf_r);
        code_s    = 4'd0;
        an_next_s = 4'b1111;
        blank_s   = 1'b0;
        case (idx_r)
            2'd0: begin
                code_s    = one_r;
                an_next_s = 4'b1110;
            end
            2'd1: begin
                code_s    = ten_r;
                an_next_s = 4'b1101;
`ifdef BCD_DISPLAY_BLANK_EN
                // A dash above (non-zero code) stops the blanking chain.
                blank_s   = (ovf_r == 10'd0) && (hun_r == 4'd0) && (ten_r == 4'd0);
`else
                blank_s   = 1'b0;
`endif
            end
            2'd2: begin
                code_s    = hun_r;
                an_next_s = 4'b1011;
`ifdef BCD_DISPLAY_BLANK_EN
                blank_s   = (ovf_r == 10'd0) && (hun_r == 4'd0);
`else
                blank_s   = 1'b0;
`endif
            end
            2'd3: begin
                code_s    = rank_s;
                an_next_s = 4'b0111;
`ifdef BCD_DISPLAY_BLANK_EN
                // Rank 10 also shows 0 but is a real overflow, so test the ladder.
                blank_s   = (ovf_r == 10'd0);
`else
                blank_s   = 1'b0;
`endif
            end
            default: begin
                code_s    = 4'd0;
                an_next_s = 4'b1111;
                blank_s   = 1'b0;
            end
        endcase
        if (blank_s) begin
            seg_next_s = SEG_OFF;
        end else begin
            seg_next_s = bcd_to_seg(code_s);
        end
    end

    // Registered display outputs, one cycle behind the index and snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            busy_digit <= 2'd0;
        end else begin
            an         <= an_next_s;
            seg        <= seg_next_s;
            busy_digit <= idx_r;
        end
    end

endmodule
